// File: rtl/clk_div_ctrl.sv
// Run-time programmable even clock divider (ratio 2*H) with clean start/stop and
// boundary-synchronous ratio updates. Define DIV_STATUS_EN to add the period_cnt status counter.
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             bit_stb,
  output logic             busy
`ifdef DIV_STATUS_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic             pend_q, pend_d;
  logic             lead_q, lead_d;
  logic             clk_out_d, stb_d;
  logic             cfg_acc, last, rise, stop;
  logic [CNT_W-1:0] cfg_val;

  assign cfg_ready = !pend_q;
  assign busy      = (state_q != IDLE);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_val   = (cfg_half == '0) ? ONE : cfg_half;
  assign last      = (count_q == h_q - ONE);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    h_d       = h_q;
    p_d       = p_q;
    pend_d    = pend_q;
    lead_d    = lead_q;
    clk_out_d = clk_out;
    stb_d     = 1'b0;
    rise      = 1'b0;
    stop      = 1'b0;
    case (state_q)
      IDLE: begin
        count_d   = '0;
        clk_out_d = 1'b0;
        lead_d    = 1'b1;
        if (cfg_acc) h_d = cfg_val;
        if (en) state_d = RUN;
      end
      RUN, DRAIN: begin
        state_d = en ? RUN : DRAIN;
        if (!last) begin
          count_d = count_q + ONE;
        end else begin
          count_d = '0;
          // Start-up holds clk_out low for one extra half-period, so the
          // first rise lands 2H edges after RUN entry.
          if (clk_out)                    clk_out_d = 1'b0;
          else if (lead_q)                lead_d    = 1'b0;
          else if (state_q == DRAIN && !en) stop    = 1'b1;
          else                            rise      = 1'b1;
        end
        if ((rise || stop) && pend_q) begin
          h_d    = p_q;
          pend_d = 1'b0;
        end
        if (rise) begin
          clk_out_d = 1'b1;
          stb_d     = 1'b1;
        end
        if (stop) state_d = IDLE;
        // A config landing on the stop edge goes straight to H, as it would in IDLE.
        if (cfg_acc) begin
          if (stop) begin
            h_d = cfg_val;
          end else begin
            p_d    = cfg_val;
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      h_q     <= DEF_H;
      p_q     <= '0;
      pend_q  <= 1'b0;
      lead_q  <= 1'b1;
      clk_out <= 1'b0;
      bit_stb <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      h_q     <= h_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      lead_q  <= lead_d;
      clk_out <= clk_out_d;
      bit_stb <= stb_d;
    end
  end

`ifdef DIV_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      period_cnt <= '0;
    else if (stop) period_cnt <= '0;
    else if (rise) period_cnt <= period_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a cycle-accurate vector table followed by
// hand-written multi-cycle sequences measuring edge counts between clk_out transitions.
module tb_clk_div_ctrl;
  logic       clk, rst, en, cfg_valid;
  logic [7:0] cfg_half;
  logic       cfg_ready, clk_out, bit_stb, busy;

  int npass = 0;
  int ntot  = 0;

  clk_div_ctrl #(.CNT_W(8), .DEF_HALF(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
    .cfg_ready(cfg_ready), .clk_out(clk_out), .bit_stb(bit_stb), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       en;
    logic       cv;
    logic [7:0] half;
    logic       c;
    logic       s;
    logic       b;
    logic       r;
  } vec_t;
  vec_t tbl [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges until clk_out makes a transition to 'want'; -1 if the budget runs out.
  task automatic wait_edge(input logic want, input int budget, output int n);
    logic prev;
    prev = clk_out;
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (prev !== want && clk_out === want) begin
        n = k;
        return;
      end
      prev = clk_out;
    end
  endtask

  task automatic stop_idle(input int budget, output int n, output int stbs);
    en = 1'b0;
    n = -1;
    stbs = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (bit_stb) stbs++;
      if (!busy) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic set_row(input int i, input logic e, input logic v, input logic [7:0] h,
                         input logic c, input logic s, input logic b, input logic r);
    tbl[i] = '{en: e, cv: v, half: h, c: c, s: s, b: b, r: r};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stbs;
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = 8'd0;

    // Idle config of H=3, run two periods, then stop from the high phase.
    set_row(0, 0, 1, 8'd3, 0, 0, 0, 1);
    set_row(1, 1, 0, 8'd0, 0, 0, 1, 1);
    for (int i = 2; i <= 6; i++) set_row(i, 1, 0, 8'd0, 0, 0, 1, 1);
    set_row(7, 1, 0, 8'd0, 1, 1, 1, 1);
    set_row(8, 1, 0, 8'd0, 1, 0, 1, 1);
    set_row(9, 1, 0, 8'd0, 1, 0, 1, 1);
    for (int i = 10; i <= 12; i++) set_row(i, 1, 0, 8'd0, 0, 0, 1, 1);
    set_row(13, 1, 0, 8'd0, 1, 1, 1, 1);
    set_row(14, 0, 0, 8'd0, 1, 0, 1, 1);
    set_row(15, 0, 0, 8'd0, 1, 0, 1, 1);
    for (int i = 16; i <= 18; i++) set_row(i, 0, 0, 8'd0, 0, 0, 1, 1);
    set_row(19, 0, 0, 8'd0, 0, 0, 0, 1);
    set_row(20, 0, 0, 8'd0, 0, 0, 0, 1);

    #12;
    chk("reset clk_out", clk_out, 0);
    chk("reset bit_stb", bit_stb, 0);
    chk("reset busy", busy, 0);
    chk("reset cfg_ready", cfg_ready, 1);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; cfg_valid = tbl[i].cv; cfg_half = tbl[i].half;
      step();
      chk($sformatf("vec%0d clk_out", i), clk_out, tbl[i].c);
      chk($sformatf("vec%0d bit_stb", i), bit_stb, tbl[i].s);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].b);
      chk($sformatf("vec%0d cfg_ready", i), cfg_ready, tbl[i].r);
    end
    cfg_valid = 1'b0;

    // Default divide-by-16 from reset.
    rst = 1'b0; #1; rst = 1'b1;
    en = 1'b1; step();
    chk("t1 busy", busy, 1);
    wait_edge(1'b1, 40, n); chk("t1 first rise", n, 16);
    chk("t1 stb at rise", bit_stb, 1);
    wait_edge(1'b0, 40, n); chk("t1 high", n, 8);
    wait_edge(1'b1, 40, n); chk("t1 low", n, 8);
    chk("t1 stb at rise2", bit_stb, 1);
    step();
    chk("t1 stb cleared", bit_stb, 0);
    chk("t1 clk_out high", clk_out, 1);

    // Live ratio change to H=2 offered mid high phase.
    chk("t3 ready before", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_half = 8'd2; step(); cfg_valid = 1'b0;
    chk("t3 ready pending", cfg_ready, 0);
    wait_edge(1'b0, 40, n); chk("t3 old high rest", n, 6);
    chk("t3 ready still pending", cfg_ready, 0);
    wait_edge(1'b1, 40, n); chk("t3 old low", n, 8);
    chk("t3 ready after apply", cfg_ready, 1);
    wait_edge(1'b0, 40, n); chk("t3 new high", n, 2);
    wait_edge(1'b1, 40, n); chk("t3 new low", n, 2);

    // Back-to-back configs: second held off until the first is applied.
    cfg_valid = 1'b1; cfg_half = 8'd4; step();
    chk("t5 b2b ready low", cfg_ready, 0);
    cfg_half = 8'd5;
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (cfg_ready) begin n = k; break; end
    end
    chk("t5 b2b ready wait", n, 3);
    chk("t5 b2b at rise", clk_out, 1);
    step(); cfg_valid = 1'b0;
    chk("t5 b2b second taken", cfg_ready, 0);
    wait_edge(1'b0, 40, n); chk("t5 b2b high4 rest", n, 3);
    wait_edge(1'b1, 40, n); chk("t5 b2b low4", n, 4);
    wait_edge(1'b0, 40, n); chk("t5 b2b high5", n, 5);
    wait_edge(1'b1, 40, n); chk("t5 b2b low5", n, 5);

    // Stop mid high phase at H=5: finish the period, no extra strobe.
    en = 1'b0; step();
    wait_edge(1'b0, 40, n); chk("t4 drain high", n, 4);
    stop_idle(40, n, stbs);
    chk("t4 drain low", n, 5);
    chk("t4 drain stbs", stbs, 0);
    chk("t4 idle clk_out", clk_out, 0);
    chk("t4 idle ready", cfg_ready, 1);

    // Restart, then re-raise en during DRAIN.
    en = 1'b1; step();
    wait_edge(1'b1, 40, n); chk("t4 restart rise", n, 10);
    en = 1'b0; step(); step(); step();
    chk("t4 drain busy", busy, 1);
    en = 1'b1;
    wait_edge(1'b0, 40, n); chk("t4 resume high", n, 2);
    wait_edge(1'b1, 40, n); chk("t4 resume low", n, 5);
    chk("t4 resume busy", busy, 1);

    // cfg_half=0 clamps to divide-by-2.
    stop_idle(40, n, stbs);
    chk("t5 zero idle", busy, 0);
    cfg_valid = 1'b1; cfg_half = 8'd0; step(); cfg_valid = 1'b0;
    chk("t5 zero ready", cfg_ready, 1);
    en = 1'b1; step();
    wait_edge(1'b1, 20, n); chk("t5 zero first rise", n, 2);
    chk("t5 zero stb", bit_stb, 1);
    step();
    chk("t5 zero stb off", bit_stb, 0);
    chk("t5 zero clk low", clk_out, 0);
    step();
    chk("t5 zero stb again", bit_stb, 1);
    chk("t5 zero clk high", clk_out, 1);

    // Maximum half-period: period 510.
    stop_idle(40, n, stbs);
    cfg_valid = 1'b1; cfg_half = 8'd255; step(); cfg_valid = 1'b0;
    en = 1'b1; step();
    wait_edge(1'b1, 1200, n); chk("t5 max first rise", n, 510);
    wait_edge(1'b0, 600, n); chk("t5 max high", n, 255);
    wait_edge(1'b1, 600, n); chk("t5 max low", n, 255);

    // Async reset with a config pending.
    cfg_valid = 1'b1; cfg_half = 8'd7; step(); cfg_valid = 1'b0;
    chk("t6 pending", cfg_ready, 0);
    step(); step();
    #2; rst = 1'b0; #1;
    chk("t6 rst clk_out", clk_out, 0);
    chk("t6 rst busy", busy, 0);
    chk("t6 rst ready", cfg_ready, 1);
    chk("t6 rst stb", bit_stb, 0);
    en = 1'b0;
    #10; rst = 1'b1;
    step();
    en = 1'b1; step();
    wait_edge(1'b1, 40, n); chk("t6 default rise", n, 16);
    wait_edge(1'b0, 40, n); chk("t6 default high", n, 8);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
